cache_ctrl: RTL and testbench

CACHE_CTRL -- requirements
Module: cache_ctrl

---
 rtl/cache_ctrl.sv | 156 +++++++++++++++
 tb/tb_cache_ctrl.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller: 256 lines x 4 words of 16 bits.
// Tag/valid/dirty live here; the data array and main memory sit outside the block.
module cache_ctrl (
  input  logic        clock,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [12:0] cpu_addr,
  input  logic [15:0] cpu_wdata,
  output logic [15:0] cpu_rdata,
  output logic        cpu_ready,
  output logic        cpu_busy,
  output logic [9:0]  da_addr,
  output logic        da_we,
  output logic [15:0] da_wdata,
  input  logic [15:0] da_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [12:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        hit,
  output logic        miss
);

  typedef enum logic [1:0] {StIdle, StCompare, StWriteback, StAllocate} state_e;

  state_e       state_q;
  logic [12:0]  addr_q;
  logic         we_q;
  logic [15:0]  wdata_q;
  logic [1:0]   beat_q;
  logic [255:0] valid_q;
  logic [255:0] dirty_q;
  logic [2:0]   tag_mem [256];

  logic [2:0] req_tag;
  logic [7:0] req_idx;
  logic [1:0] req_word;
  logic [2:0] line_tag;
  logic       line_hit;
  logic       last_beat;

  assign req_tag   = addr_q[12:10];
  assign req_idx   = addr_q[9:2];
  assign req_word  = addr_q[1:0];
  assign line_tag  = tag_mem[req_idx];
  assign line_hit  = valid_q[req_idx] && (line_tag == req_tag);
  assign last_beat = mem_ack && (beat_q == 2'd3);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      we_q    <= 1'b0;
      wdata_q <= '0;
      beat_q  <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (cpu_req) begin
            addr_q  <= cpu_addr;
            we_q    <= cpu_we;
            wdata_q <= cpu_wdata;
            state_q <= StCompare;
          end
        end
        StCompare: begin
          if (line_hit) begin
            if (we_q) dirty_q[req_idx] <= 1'b1;
            state_q <= StIdle;
          end else begin
            beat_q  <= '0;
            state_q <= (valid_q[req_idx] && dirty_q[req_idx]) ? StWriteback : StAllocate;
          end
        end
        StWriteback: begin
          // Beat counter wraps to 0 on the last ack, ready for the allocate burst.
          if (mem_ack) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) state_q <= StAllocate;
          end
        end
        StAllocate: begin
          if (mem_ack) begin
            beat_q <= beat_q + 2'd1;
            if (beat_q == 2'd3) begin
              valid_q[req_idx] <= 1'b1;
              dirty_q[req_idx] <= 1'b0;
              state_q          <= StCompare;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Tags need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clock) begin
    if (state_q == StAllocate && last_beat) tag_mem[req_idx] <= req_tag;
  end

  always_comb begin
    cpu_rdata = '0;
    cpu_ready = 1'b0;
    cpu_busy  = (state_q != StIdle);
    da_addr   = '0;
    da_we     = 1'b0;
    da_wdata  = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    hit       = 1'b0;
    miss      = 1'b0;
    case (state_q)
      StCompare: begin
        da_addr = {req_idx, req_word};
        if (line_hit) begin
          hit       = 1'b1;
          cpu_ready = 1'b1;
          if (we_q) begin
            da_we    = 1'b1;
            da_wdata = wdata_q;
          end else begin
            cpu_rdata = da_rdata;
          end
        end else begin
          miss = 1'b1;
        end
      end
      StWriteback: begin
        da_addr   = {req_idx, beat_q};
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {line_tag, req_idx, beat_q};
        mem_wdata = da_rdata;
      end
      StAllocate: begin
        da_addr  = {req_idx, beat_q};
        mem_req  = 1'b1;
        mem_addr = {req_tag, req_idx, beat_q};
        if (mem_ack) begin
          da_we    = 1'b1;
          da_wdata = mem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cache_ctrl.sv
// Self-checking bench for cache_ctrl: directed scenarios plus random traffic, all checked
// against a plain array model of a direct-mapped write-back cache.
module tb_cache_ctrl;

  logic        clock = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_req = 1'b0;
  logic        cpu_we = 1'b0;
  logic [12:0] cpu_addr = '0;
  logic [15:0] cpu_wdata = '0;
  logic [15:0] cpu_rdata;
  logic        cpu_ready;
  logic        cpu_busy;
  logic [9:0]  da_addr;
  logic        da_we;
  logic [15:0] da_wdata;
  logic [15:0] da_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic        hit;
  logic        miss;

  cache_ctrl dut (
    .clock    (clock),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .cpu_busy (cpu_busy),
    .da_addr  (da_addr),
    .da_we    (da_we),
    .da_wdata (da_wdata),
    .da_rdata (da_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .hit      (hit),
    .miss     (miss)
  );

  always #5 clock = ~clock;

  // External data array: combinational read, write on the rising edge.
  logic [15:0] da_mem [1024];
  assign da_rdata = da_mem[da_addr];
  always @(posedge clock) if (da_we) da_mem[da_addr] <= da_wdata;

  // Main memory seen by the DUT, and the reference model's own view of memory and cache.
  logic [15:0] mem_model [8192];
  logic [15:0] ref_main [8192];
  bit          ref_valid [256];
  bit          ref_dirty [256];
  logic [2:0]  ref_tag [256];
  logic [15:0] ref_data [256][4];

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"}, {cpu_ready, cpu_busy, da_we, mem_req, mem_we, hit, miss,
                             da_addr, mem_addr}, 64'd0);
    check_eq({tag, "_data"}, {cpu_rdata, da_wdata, mem_wdata}, 64'd0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 256; i++) begin
      ref_valid[i] = 1'b0;
      ref_dirty[i] = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n, input bit noise);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      check_eq("idle_busy", cpu_busy, 0);
      check_eq("idle_mem_req", mem_req, 0);
      check_eq("idle_da_we", da_we, 0);
      mem_ack   = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      mem_rdata = 16'($urandom);
    end
  endtask

  // One CPU access. delay = wait cycles before each ack; rst_beat >= 0 resets the DUT
  // at the start of that allocate beat.
  task automatic access(input bit we, input logic [12:0] addr, input logic [15:0] wdata,
                        input int delay, input int rst_beat, input bit noise);
    logic [7:0]  idx;
    logic [2:0]  tag;
    logic [1:0]  w;
    bit          exp_hit, exp_wb, done, aborted;
    logic [12:0] exp_wb_addr [4];
    logic [15:0] exp_wb_data [4];
    logic [12:0] exp_rd_addr [4];
    logic [12:0] got_wb_addr [4];
    logic [15:0] got_wb_data [4];
    logic [12:0] got_rd_addr [4];
    logic [15:0] exp_rdata;
    logic [12:0] hold_addr;
    logic [15:0] hold_wdata;
    logic        hold_we;
    int          cycles, nwb, nrd, misses, hits, wait_cnt, exp_lat;

    idx = addr[9:2];
    tag = addr[12:10];
    w   = addr[1:0];
    exp_hit = ref_valid[idx] && (ref_tag[idx] == tag);
    exp_wb  = !exp_hit && ref_valid[idx] && ref_dirty[idx];
    for (int b = 0; b < 4; b++) begin
      exp_wb_addr[b] = {ref_tag[idx], idx, b[1:0]};
      exp_wb_data[b] = ref_data[idx][b];
      exp_rd_addr[b] = {tag, idx, b[1:0]};
    end
    if (!exp_hit) begin
      if (exp_wb) for (int b = 0; b < 4; b++) ref_main[exp_wb_addr[b]] = exp_wb_data[b];
      for (int b = 0; b < 4; b++) ref_data[idx][b] = ref_main[exp_rd_addr[b]];
      ref_valid[idx] = 1'b1;
      ref_dirty[idx] = 1'b0;
      ref_tag[idx]   = tag;
    end
    if (we) begin
      ref_data[idx][w] = wdata;
      ref_dirty[idx]   = 1'b1;
    end
    exp_rdata = ref_data[idx][w];
    // Request cycle + compare, plus a second compare and every memory beat on a miss.
    exp_lat = exp_hit ? 2 : 3 + (exp_wb ? 8 : 4) * (delay + 1);

    @(negedge clock);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; mem_ack = 1'b0;
    @(negedge clock);
    cpu_req = 1'b0;
    cycles = 0; nwb = 0; nrd = 0; misses = 0; hits = 0; wait_cnt = 0;
    done = 1'b0; aborted = 1'b0;
    hold_addr = '0; hold_wdata = '0; hold_we = 1'b0;

    while (!done && cycles < 400) begin
      cycles++;
      mem_ack = 1'b0;
      if (miss) misses++;
      if (hit) hits++;
      if (cpu_ready) begin
        done = 1'b1;
        check_eq("latency", cycles + 1, exp_lat);
        check_eq("busy_at_ready", cpu_busy, 1);
        if (we) begin
          check_eq("wr_da_we", da_we, 1);
          check_eq("wr_da_addr", da_addr, {idx, w});
          check_eq("wr_da_wdata", da_wdata, wdata);
        end else begin
          check_eq("rd_da_we", da_we, 0);
          check_eq("rd_data", cpu_rdata, exp_rdata);
        end
      end else if (mem_req) begin
        if (wait_cnt == 0) begin
          hold_addr = mem_addr; hold_we = mem_we; hold_wdata = mem_wdata;
        end else begin
          check_eq("hold_addr", mem_addr, hold_addr);
          check_eq("hold_we", mem_we, hold_we);
          if (hold_we) check_eq("hold_wdata", mem_wdata, hold_wdata);
        end
        if (rst_beat >= 0 && !mem_we && nrd == rst_beat && wait_cnt == 0) begin
          rst = 1'b0;
          #1;
          check_reset_outputs("midburst_rst");
          aborted = 1'b1;
          done    = 1'b1;
        end else if (wait_cnt < delay) begin
          wait_cnt++;
        end else begin
          wait_cnt = 0;
          mem_ack  = 1'b1;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            if (nwb < 4) begin
              got_wb_addr[nwb] = mem_addr;
              got_wb_data[nwb] = mem_wdata;
            end
            nwb++;
          end else begin
            mem_rdata = mem_model[mem_addr];
            if (nrd < 4) got_rd_addr[nrd] = mem_addr;
            nrd++;
          end
        end
      end
      if (!done) begin
        if (noise) begin
          cpu_req   = 1'($urandom_range(0, 1));
          cpu_we    = 1'($urandom_range(0, 1));
          cpu_addr  = 13'($urandom);
          cpu_wdata = 16'($urandom);
        end
        @(negedge clock);
      end
    end
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    check_eq("completed", done, 1);

    if (aborted) begin
      @(negedge clock);
      rst = 1'b1;
      model_reset();
    end else begin
      check_eq("miss_pulses", misses, exp_hit ? 0 : 1);
      check_eq("hit_pulses", hits, 1);
      check_eq("wb_beats", nwb, exp_wb ? 4 : 0);
      check_eq("rd_beats", nrd, exp_hit ? 0 : 4);
      for (int b = 0; b < 4 && b < nwb; b++) begin
        check_eq("wb_addr", got_wb_addr[b], exp_wb_addr[b]);
        check_eq("wb_data", got_wb_data[b], exp_wb_data[b]);
      end
      for (int b = 0; b < 4 && b < nrd; b++) check_eq("rd_addr", got_rd_addr[b], exp_rd_addr[b]);
    end
  endtask

  logic [7:0] idx_pool [4];

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem_model[i] = 16'($urandom);
      ref_main[i]  = mem_model[i];
    end
    for (int i = 0; i < 4; i++) begin
      mem_model[4 + i] = 16'hA0 + 16'(i);
      ref_main[4 + i]  = mem_model[4 + i];
    end
    for (int i = 0; i < 256; i++) begin
      ref_tag[i] = '0;
      for (int b = 0; b < 4; b++) ref_data[i][b] = '0;
    end
    model_reset();

    repeat (3) @(negedge clock);
    check_reset_outputs("reset");
    rst = 1'b1;

    // Cold read miss, write hit, read hit.
    access(1'b0, 13'h0005, 16'h0000, 0, -1, 1'b0);
    access(1'b1, 13'h0005, 16'h1234, 0, -1, 1'b0);
    access(1'b0, 13'h0005, 16'h0000, 0, -1, 1'b0);
    // Conflicting tag forces write-back of the dirty line; slow memory.
    access(1'b0, 13'h0405, 16'h0000, 5, -1, 1'b0);
    // Reset during allocate beat 2, then the line must refill from scratch.
    access(1'b0, 13'h0005, 16'h0000, 1, 2, 1'b0);
    access(1'b0, 13'h0005, 16'h0000, 0, -1, 1'b0);
    idle_cycles(4, 1'b1);

    idx_pool[0] = 8'd1; idx_pool[1] = 8'd2; idx_pool[2] = 8'd3; idx_pool[3] = 8'd200;
    for (int n = 0; n < 200; n++) begin
      access(1'($urandom_range(0, 1)),
             {3'($urandom_range(0, 7)), idx_pool[$urandom_range(0, 3)], 2'($urandom_range(0, 3))},
             16'($urandom), int'($urandom_range(0, 2)), -1, 1'b1);
      idle_cycles(int'($urandom_range(1, 3)), 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
